arbiter_quantum: RTL and testbench
==================================

// Module: arbiter_quantum
// PURPOSE
//  Round-robin arbiter for a shared resource where the owner keeps its grant
//  across consecutive cycles while it holds its request. Ownership is capped at
//  QUANTUM cycles whenever another port is waiting.
//  Sits between NUM_PORTS requesters and the shared-resource mux.
//  Hands over ownership with no idle bubble and pulses `expired` on each forced rotation.
// PARAMETERS
//  NUM_PORTS  6                  number of requesters, >=2
//  QUANTUM    8                  max consecutive grant cycles while others wait, >=1
//  SEL_WIDTH  $clog2(NUM_PORTS)  derived, never overridden
//  CNT_WIDTH  $clog2(QUANTUM+1)  derived, never overridden
// PORTS
//  clk      in   1          single clock, all logic on posedge
//  rst      in   1          synchronous, active-high reset
//  request  in   NUM_PORTS  bit i high = port i wants or keeps ownership
//  grant    out  NUM_PORTS  registered one-hot owner, all-zero when idle
//  select   out  SEL_WIDTH  binary index of owner, 0 when idle
//  active   out  1          registered, equals |grant
//  expired  out  1          1-cycle pulse, coincides with first cycle of a forced-rotation grant
// BEHAVIOUR
//  Reset: grant=0, select=0, active=0, expired=0, ptr=0, cnt=0, state=IDLE.
//   - Reset sampled mid-grant: all outputs are 0 in the next cycle.
//   - Request is ignored on any cycle where rst=1.
//  Winner search: first set bit of a candidate vector, scanning ptr, ptr+1, ...
//   wrapping modulo NUM_PORTS. On every new grant to port w, ptr <= (w+1)%NUM_PORTS.
//  Latency: request sampled at posedge t yields grant at t+1. No combinational
//   path from request to any output.
//  States:
//   - IDLE: if request!=0, grant winner(request); cnt<=1; go to OWN.
//     Otherwise stay in IDLE with outputs 0.
//   - OWN (owner w), evaluated in priority order:
//     a) request[w]==0 (release): if others!=0, grant winner(others) next cycle,
//        cnt<=1, expired=0 (zero-bubble handover). Otherwise grant<=0, go to IDLE.
//     b) cnt==QUANTUM and others!=0: grant winner(others), cnt<=1, expired<=1.
//     c) cnt==QUANTUM and others==0: keep grant; cnt saturates at QUANTUM.
//        A later competitor seen at t therefore takes the grant at t+1.
//     d) Otherwise keep grant; cnt<=cnt+1.
//   - others = request & ~grant. The owner is never re-selected by a forced
//     rotation, since ptr places it last.
//  Counting: cnt counts grant cycles including the current one, so the owner
//   holds for exactly QUANTUM cycles under contention.
//  QUANTUM=1 degenerates to per-cycle round-robin.
//  select and active are updated in the same cycle as grant. expired is 0 in every other cycle.
// TESTING
//  (all with NUM_PORTS=6)
//  1 Reset: rst=1 for 2 cycles with request=6'b111111
//    -> grant=0, select=0, active=0, expired=0 throughout.
//    Release rst with request=6'b001010 -> grant=6'b000010, select=1 one cycle later.
//  2 Quantum (QUANTUM=4): from reset, request=6'b000011 held
//    -> grant 000001 for 4 cycles, then 000010 for 4 cycles (expired=1 on its
//    first cycle), then 000001 again; no idle cycle between owners.
//  3 Lone owner (QUANTUM=4): request=6'b000100 for 20 cycles
//    -> grant=000100 all 20 cycles, expired=0.
//    Then raise request[0] at t -> grant=000001 and expired=1 at t+1.
//  4 Early release: port 0 owns (cnt=2, QUANTUM=8) and request[5]=1.
//    Drop request[0] -> next cycle grant=6'b100000, select=5, active=1, expired=0.
//  5 Wrap (QUANTUM=1): request=6'b111111
//    -> grant 000001, 000010, 000100, 001000, 010000, 100000, then 000001 again,
//    expired=1 on every grant after the first.
//  6 Mid-grant reset: port 3 owns, assert rst for 1 cycle with request=6'b001000
//    -> next cycle all outputs 0. After release, grant=6'b001000 one cycle later
//    with cnt restarted at 1.

Source files
------------

// File: rtl/arbiter_quantum.sv
// Round-robin arbiter with sticky ownership, capped at QUANTUM cycles while others wait.
// Registered outputs: request sampled at one posedge drives grant after it; handover has no idle bubble.
module arbiter_quantum #(
  parameter int NUM_PORTS = 6,
  parameter int QUANTUM   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         request,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [$clog2(NUM_PORTS)-1:0] select,
  output logic                         active,
  output logic                         expired
);
  localparam int SEL_WIDTH = $clog2(NUM_PORTS);
  localparam int CNT_WIDTH = $clog2(QUANTUM + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(QUANTUM);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_PORTS - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e                 state_q,   state_d;
  logic [NUM_PORTS-1:0]   grant_q,   grant_d;
  logic [SEL_WIDTH-1:0]   select_q,  select_d;
  logic                   active_q,  active_d;
  logic                   expired_q, expired_d;
  logic [SEL_WIDTH-1:0]   ptr_q,     ptr_d;
  logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;

  logic [NUM_PORTS-1:0]   others;
  logic                   take;
  logic [SEL_WIDTH-1:0]   take_sel;

  // First set bit of vec scanning start, start+1, ... with wrap.
  function automatic logic [SEL_WIDTH-1:0] pick(input logic [NUM_PORTS-1:0] vec,
                                                input logic [SEL_WIDTH-1:0] start);
    logic [SEL_WIDTH-1:0] res;
    logic [SEL_WIDTH-1:0] sel;
    logic                 found;
    int                   pos;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = int'(start) + i;
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      sel = SEL_WIDTH'(pos);
      if (!found && vec[sel]) begin
        res   = sel;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign others = request & ~grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    select_d  = select_q;
    active_d  = active_q;
    expired_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    take_sel  = '0;

    case (state_q)
      IDLE: begin
        if (|request) begin
          take     = 1'b1;
          take_sel = pick(request, ptr_q);
        end
      end
      OWN: begin
        if (!request[select_q]) begin
          if (|others) begin
            take     = 1'b1;
            take_sel = pick(others, ptr_q);
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            select_d = '0;
            active_d = 1'b0;
            cnt_d    = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          // Saturated owner with no competitor simply keeps the grant.
          if (|others) begin
            take      = 1'b1;
            take_sel  = pick(others, ptr_q);
            expired_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d  = OWN;
      grant_d  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << take_sel;
      select_d = take_sel;
      active_d = 1'b1;
      cnt_d    = CNT_ONE;
      ptr_d    = (take_sel == SEL_LAST) ? '0 : take_sel + SEL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      select_q  <= '0;
      active_q  <= 1'b0;
      expired_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      select_q  <= select_d;
      active_q  <= active_d;
      expired_q <= expired_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign select  = select_q;
  assign active  = active_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_arbiter_quantum.sv
// Bench for arbiter_quantum: three instances (QUANTUM 4, 8, 1) share one stimulus,
// a rule-level model tracks each, plus a vector table and directed corner sequences.
module tb_arbiter_quantum;
  localparam int N = 6;
  localparam int QV[3] = '{4, 8, 1};

  logic         clk;
  logic         rst;
  logic [N-1:0] request;
  logic [N-1:0] g[3];
  logic [2:0]   s[3];
  logic         a[3];
  logic         e[3];

  int checks   = 0;
  int failures = 0;

  arbiter_quantum #(.NUM_PORTS(N), .QUANTUM(4)) u_q4 (
    .clk(clk), .rst(rst), .request(request),
    .grant(g[0]), .select(s[0]), .active(a[0]), .expired(e[0]));
  arbiter_quantum #(.NUM_PORTS(N), .QUANTUM(8)) u_q8 (
    .clk(clk), .rst(rst), .request(request),
    .grant(g[1]), .select(s[1]), .active(a[1]), .expired(e[1]));
  arbiter_quantum #(.NUM_PORTS(N), .QUANTUM(1)) u_q1 (
    .clk(clk), .rst(rst), .request(request),
    .grant(g[2]), .select(s[2]), .active(a[2]), .expired(e[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input int k, input logic [N-1:0] eg,
                         input logic [2:0] es, input logic ea, input logic ee);
    chk({nm, ".grant"},   32'(g[k]), 32'(eg));
    chk({nm, ".select"},  32'(s[k]), 32'(es));
    chk({nm, ".active"},  32'(a[k]), 32'(ea));
    chk({nm, ".expired"}, 32'(e[k]), 32'(ee));
  endtask

  // Reference model: owner index (-1 when idle), cycles held, round-robin start.
  int m_own[3];
  int m_cnt[3];
  int m_ptr[3];
  bit m_exp[3];
  bit m_ok = 1'b0;

  function automatic int first_from(input logic [N-1:0] v, input int start);
    for (int ofs = 0; ofs < N; ofs++) begin
      if (v[(start + ofs) % N]) return (start + ofs) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(input int q, input logic r, input logic [N-1:0] req,
                                     inout int own, inout int cnt, inout int ptr, output bit ex);
    int w;
    logic [N-1:0] oth;
    ex = 1'b0;
    if (r) begin
      own = -1; cnt = 0; ptr = 0;
      return;
    end
    if (own < 0 || !req[own]) begin
      w = first_from(req, ptr);
      own = w;
      if (w >= 0) begin
        cnt = 1; ptr = (w + 1) % N;
      end else begin
        cnt = 0;
      end
    end else if (cnt >= q) begin
      oth = req;
      oth[own] = 1'b0;
      w = first_from(oth, ptr);
      if (w >= 0) begin
        own = w; cnt = 1; ptr = (w + 1) % N; ex = 1'b1;
      end
    end else begin
      cnt = cnt + 1;
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int o, c, p;
      bit x;
      o = m_own[k]; c = m_cnt[k]; p = m_ptr[k];
      model_step(QV[k], rst, request, o, c, p, x);
      m_own[k] <= o; m_cnt[k] <= c; m_ptr[k] <= p; m_exp[k] <= x;
    end
    m_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int k = 0; k < 3; k++) begin
        logic [N-1:0] eg;
        eg = (m_own[k] < 0) ? '0 : (N'(1) << m_own[k]);
        chk_out($sformatf("model_q%0d", QV[k]), k, eg,
                (m_own[k] < 0) ? 3'd0 : 3'(m_own[k]), m_own[k] >= 0, m_exp[k]);
      end
    end
  end

  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic [N-1:0] eg;
    logic [2:0]   es;
    logic         ea;
    logic         ee;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic [N-1:0] req, input logic [N-1:0] eg,
                              input logic [2:0] es, input logic ea, input logic ee);
    vec_t v;
    v.r = r; v.req = req; v.eg = eg; v.es = es; v.ea = ea; v.ee = ee;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [N-1:0] req);
    rst = r;
    request = req;
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] one;
    logic [N-1:0] cur;
    rst = 1'b1;
    request = '0;
    @(negedge clk);

    // Vector table, checked against the QUANTUM=4 instance.
    add(1, 6'b111111, 6'b000000, 3'd0, 0, 0);
    add(1, 6'b111111, 6'b000000, 3'd0, 0, 0);
    add(0, 6'b001010, 6'b000010, 3'd1, 1, 0);
    add(1, 6'b000011, 6'b000000, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 6'b000011, 6'b000001, 3'd0, 1, 0);
    add(0, 6'b000011, 6'b000010, 3'd1, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 6'b000011, 6'b000010, 3'd1, 1, 0);
    add(0, 6'b000011, 6'b000001, 3'd0, 1, 1);
    add(1, 6'b000100, 6'b000000, 3'd0, 0, 0);
    for (int i = 0; i < 20; i++) add(0, 6'b000100, 6'b000100, 3'd2, 1, 0);
    add(0, 6'b000101, 6'b000001, 3'd0, 1, 1);
    add(1, 6'b001000, 6'b000000, 3'd0, 0, 0);
    add(0, 6'b001000, 6'b001000, 3'd3, 1, 0);
    add(0, 6'b001000, 6'b001000, 3'd3, 1, 0);
    add(1, 6'b001000, 6'b000000, 3'd0, 0, 0);
    add(0, 6'b001000, 6'b001000, 3'd3, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 6'b001001, 6'b001000, 3'd3, 1, 0);
    add(0, 6'b001001, 6'b000001, 3'd0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].req);
      chk_out($sformatf("tbl[%0d]", i), 0, tbl[i].eg, tbl[i].es, tbl[i].ea, tbl[i].ee);
    end

    // Early release with a waiter: zero-bubble handover to port 5, QUANTUM=8.
    step(1, 6'b000000);
    step(0, 6'b000001);
    chk_out("release_own", 1, 6'b000001, 3'd0, 1, 0);
    step(0, 6'b100001);
    chk_out("release_cnt2", 1, 6'b000001, 3'd0, 1, 0);
    step(0, 6'b100000);
    chk_out("release_handover", 1, 6'b100000, 3'd5, 1, 0);

    // Per-cycle rotation with wrap, QUANTUM=1.
    step(1, 6'b000000);
    one = 6'b000001;
    for (int i = 0; i < 7; i++) begin
      step(0, 6'b111111);
      chk_out($sformatf("wrap[%0d]", i), 2, one << (i % N), 3'(i % N), 1, i > 0);
    end

    // Random traffic with sticky requests and occasional reset.
    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
      end
      step($urandom_range(0, 63) == 0, cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
